prl_phy_tx_arbiter: RTL and testbench

- Arbitrates the single PHY transmit path among three protocol-layer requesters: Hard Reset signalling, Rx GoodCRC responses, and Tx state machine messages.
- Enforces a fixed priority, a CC-idle check for messages, an inter-frame gap after every transmission, and a transmit watchdog.
- Sits between the Rx/Tx protocol state machines and the PHY transmitter.

---
 rtl/prl_phy_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_prl_phy_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prl_phy_tx_arbiter.sv
// PHY transmit-path arbiter. Hard Reset outranks GoodCRC, which outranks messages.
// Messages also need an idle CC line. Every transaction ends in an inter-frame gap,
// and a watchdog bounds the time spent waiting for the PHY.
module prl_phy_tx_arbiter #(
  parameter int unsigned IFG_CYCLES = 8,
  parameter int unsigned TX_TIMEOUT = 1023,
  parameter int unsigned CNT_W      = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       HardReset_Req,
  input  logic       GoodCRC_Req,
  input  logic       Msg_Req,
  input  logic       CC_IDLE,
  input  logic       PHY_Tx_Done,
  output logic       PHY_Tx_Start,
  output logic [1:0] PHY_Tx_Sel,
  output logic       HardReset_Gnt,
  output logic       GoodCRC_Gnt,
  output logic       Msg_Gnt,
  output logic       Tx_Complete,
  output logic       Tx_Timeout,
  output logic       Msg_Aborted
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned GNT_W = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CRC  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MSG  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_HR   = 2'b11;

  localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_CYCLES);
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TX_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GAP   = 5'b00010,
    START = 5'b00100,
    BUSY  = 5'b01000,
    DONE  = 5'b10000
  } state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [GNT_W-1:0]   gnt_q;
  logic               start_q;
  logic               cmp_q;
  logic               tmo_q;
  logic               abt_q;
  logic [CNT_W-1:0]   wdog_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   wdog_d;
  logic [CNT_W-1:0]   gap_d;
  logic [SEL_W-1:0]   req_sel;

  // Grant vector {HardReset, GoodCRC, Msg} implied by a select code.
  function automatic logic [GNT_W-1:0] gnt_dec(input logic [SEL_W-1:0] sel);
    logic [GNT_W-1:0] g;
    g = '0;
    case (sel)
      SEL_HR:  g = 3'b100;
      SEL_CRC: g = 3'b010;
      SEL_MSG: g = 3'b001;
      default: g = '0;
    endcase
    return g;
  endfunction

  // Fixed-priority winner among the currently eligible requests.
  always_comb begin
    req_sel = SEL_NONE;
    if (HardReset_Req) begin
      req_sel = SEL_HR;
    end else if (GoodCRC_Req) begin
      req_sel = SEL_CRC;
    end else if (Msg_Req && CC_IDLE) begin
      req_sel = SEL_MSG;
    end
  end

  assign wdog_d = (wdog_q == CNT_MAX) ? wdog_q : wdog_q + CNT_ONE;
  assign gap_d  = (gap_q == '0) ? gap_q : gap_q - CNT_ONE;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      gnt_q   <= '0;
      start_q <= 1'b0;
      cmp_q   <= 1'b0;
      tmo_q   <= 1'b0;
      abt_q   <= 1'b0;
      wdog_q  <= '0;
      gap_q   <= '0;
    end else begin
      start_q <= 1'b0;
      cmp_q   <= 1'b0;
      tmo_q   <= 1'b0;
      abt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_sel != SEL_NONE) begin
            state_q <= START;
            sel_q   <= req_sel;
            gnt_q   <= gnt_dec(req_sel);
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= BUSY;
          wdog_q  <= '0;
        end
        BUSY: begin
          // A finished transfer beats both preemption and the watchdog.
          if (PHY_Tx_Done) begin
            state_q <= DONE;
            cmp_q   <= 1'b1;
          end else if ((sel_q == SEL_MSG) && HardReset_Req) begin
            state_q <= START;
            sel_q   <= SEL_HR;
            gnt_q   <= gnt_dec(SEL_HR);
            start_q <= 1'b1;
            abt_q   <= 1'b1;
          end else if (wdog_d == TMO_VAL) begin
            state_q <= DONE;
            tmo_q   <= 1'b1;
            wdog_q  <= wdog_d;
          end else begin
            wdog_q  <= wdog_d;
          end
        end
        DONE: begin
          sel_q   <= SEL_NONE;
          gnt_q   <= '0;
          gap_q   <= IFG_LOAD;
          state_q <= (IFG_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          // Hard Reset skips the remainder of the gap; other requests wait for IDLE.
          if (HardReset_Req) begin
            state_q <= START;
            sel_q   <= SEL_HR;
            gnt_q   <= gnt_dec(SEL_HR);
            start_q <= 1'b1;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_d;
            if (gap_d == '0) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= SEL_NONE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign PHY_Tx_Start  = start_q;
  assign PHY_Tx_Sel    = sel_q;
  assign HardReset_Gnt = gnt_q[2];
  assign GoodCRC_Gnt   = gnt_q[1];
  assign Msg_Gnt       = gnt_q[0];
  assign Tx_Complete   = cmp_q;
  assign Tx_Timeout    = tmo_q;
  assign Msg_Aborted   = abt_q;

endmodule

// File: tb/tb_prl_phy_tx_arbiter.sv
// Scoreboard bench for prl_phy_tx_arbiter. The bench queues expected starts and
// end-of-transaction pulses, with their cycles, at the moment it drives stimulus.
module tb_prl_phy_tx_arbiter;

  localparam int unsigned IFG = 8;
  localparam int unsigned TMO = 15;

  localparam logic [2:0] EV_CMP = 3'b001;
  localparam logic [2:0] EV_TMO = 3'b010;
  localparam logic [2:0] EV_ABT = 3'b100;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       HardReset_Req = 1'b0;
  logic       GoodCRC_Req = 1'b0;
  logic       Msg_Req = 1'b0;
  logic       CC_IDLE = 1'b1;
  logic       PHY_Tx_Done = 1'b0;
  logic       PHY_Tx_Start;
  logic [1:0] PHY_Tx_Sel;
  logic       HardReset_Gnt;
  logic       GoodCRC_Gnt;
  logic       Msg_Gnt;
  logic       Tx_Complete;
  logic       Tx_Timeout;
  logic       Msg_Aborted;

  prl_phy_tx_arbiter #(
    .IFG_CYCLES(IFG),
    .TX_TIMEOUT(TMO),
    .CNT_W(5)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .HardReset_Req(HardReset_Req),
    .GoodCRC_Req(GoodCRC_Req),
    .Msg_Req(Msg_Req),
    .CC_IDLE(CC_IDLE),
    .PHY_Tx_Done(PHY_Tx_Done),
    .PHY_Tx_Start(PHY_Tx_Start),
    .PHY_Tx_Sel(PHY_Tx_Sel),
    .HardReset_Gnt(HardReset_Gnt),
    .GoodCRC_Gnt(GoodCRC_Gnt),
    .Msg_Gnt(Msg_Gnt),
    .Tx_Complete(Tx_Complete),
    .Tx_Timeout(Tx_Timeout),
    .Msg_Aborted(Msg_Aborted)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [1:0] sel; int cyc; } st_t;
  typedef struct { logic [2:0] kind; int cyc; } ev_t;

  st_t start_sb[$];
  ev_t end_sb[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  n_starts = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_gnt(input logic [1:0] sel);
    if (sel == 2'b11) return 3'b100;
    if (sel == 2'b01) return 3'b010;
    if (sel == 2'b10) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [8:0] outs();
    return {PHY_Tx_Start, PHY_Tx_Sel, HardReset_Gnt, GoodCRC_Gnt, Msg_Gnt,
            Tx_Complete, Tx_Timeout, Msg_Aborted};
  endfunction

  task automatic push_start(input logic [1:0] sel, input int c);
    st_t e;
    e.sel = sel;
    e.cyc = c;
    start_sb.push_back(e);
  endtask

  task automatic push_end(input logic [2:0] kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    end_sb.push_back(e);
  endtask

  // Monitor: every start and end pulse is checked against the scoreboard.
  always @(negedge CLK) begin
    st_t st;
    ev_t ev;
    logic [2:0] seen;
    if (PHY_Tx_Start === 1'b1) begin
      n_starts++;
      if (start_sb.size() == 0) begin
        chk("start_unexpected", 32'(PHY_Tx_Sel), 32'hFF);
      end else begin
        st = start_sb.pop_front();
        chk("start_cyc", 32'(cyc), 32'(st.cyc));
        chk("start_sel", 32'(PHY_Tx_Sel), 32'(st.sel));
        chk("start_gnt", 32'({HardReset_Gnt, GoodCRC_Gnt, Msg_Gnt}), 32'(exp_gnt(st.sel)));
      end
    end
    seen = {Msg_Aborted, Tx_Timeout, Tx_Complete};
    if (seen !== 3'b000 && seen !== 3'bxxx) begin
      if (end_sb.size() == 0) begin
        chk("end_unexpected", 32'(seen), 32'h0);
      end else begin
        ev = end_sb.pop_front();
        chk("end_kind", 32'(seen), 32'(ev.kind));
        chk("end_cyc", 32'(cyc), 32'(ev.cyc));
      end
    end
  end

  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (PHY_Tx_Start === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      chk("start_wait", 32'h0, 32'h1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "start pulse never seen");
    end
  endtask

  // PHY reports done after b cycles in BUSY; returns the completion-pulse cycle.
  task automatic finish_tx(input int s, input int b, input logic hr_too, output int c);
    while (cyc < s + b) @(negedge CLK);
    PHY_Tx_Done = 1'b1;
    if (hr_too) HardReset_Req = 1'b1;
    c = s + b + 1;
    push_end(EV_CMP, c);
    @(negedge CLK);
    PHY_Tx_Done = 1'b0;
    HardReset_Req = 1'b0;
    @(negedge CLK);
    chk("gnt_drop", 32'({PHY_Tx_Sel, HardReset_Gnt, GoodCRC_Gnt, Msg_Gnt}), 32'h0);
  endtask

  task automatic wait_idle(input int c);
    while (cyc < c + int'(IFG) + 1) @(negedge CLK);
  endtask

  initial begin
    int s;
    int c;
    int n0;
    repeat (3) @(negedge CLK);
    chk("reset_hold", 32'(outs()), 32'h0);
    reset = 1'b1;
    @(negedge CLK);
    chk("reset_release", 32'(outs()), 32'h0);

    // GoodCRC, then a message raised during the gap waits for IDLE.
    GoodCRC_Req = 1'b1;
    push_start(2'b01, cyc + 1);
    wait_start(s);
    GoodCRC_Req = 1'b0;
    finish_tx(s, 10, 1'b0, c);
    Msg_Req = 1'b1;
    push_start(2'b10, c + int'(IFG) + 2);
    wait_start(s);
    Msg_Req = 1'b0;
    finish_tx(s, 7, 1'b0, c);

    // All three at once: HR, then GoodCRC, then message.
    wait_idle(c);
    HardReset_Req = 1'b1;
    GoodCRC_Req = 1'b1;
    Msg_Req = 1'b1;
    push_start(2'b11, cyc + 1);
    wait_start(s);
    HardReset_Req = 1'b0;
    finish_tx(s, 5, 1'b0, c);
    push_start(2'b01, c + int'(IFG) + 2);
    wait_start(s);
    GoodCRC_Req = 1'b0;
    finish_tx(s, 3, 1'b0, c);
    push_start(2'b10, c + int'(IFG) + 2);
    wait_start(s);
    Msg_Req = 1'b0;
    finish_tx(s, 4, 1'b0, c);

    // Message stalls on a busy CC line.
    wait_idle(c);
    CC_IDLE = 1'b0;
    Msg_Req = 1'b1;
    n0 = n_starts;
    repeat (50) @(negedge CLK);
    chk("cc_stall", 32'(n_starts), 32'(n0));
    CC_IDLE = 1'b1;
    push_start(2'b10, cyc + 1);
    wait_start(s);
    Msg_Req = 1'b0;

    // Hard Reset preempts the message with no gap.
    while (cyc < s + 3) @(negedge CLK);
    HardReset_Req = 1'b1;
    push_end(EV_ABT, cyc + 1);
    push_start(2'b11, cyc + 1);
    wait_start(s);
    HardReset_Req = 1'b0;
    finish_tx(s, 6, 1'b0, c);

    // Hard Reset during the gap bypasses it.
    while (cyc < c + 3) @(negedge CLK);
    HardReset_Req = 1'b1;
    push_start(2'b11, cyc + 1);
    wait_start(s);
    HardReset_Req = 1'b0;
    finish_tx(s, 2, 1'b0, c);

    // Watchdog abort after TMO cycles in BUSY.
    wait_idle(c);
    GoodCRC_Req = 1'b1;
    push_start(2'b01, cyc + 1);
    wait_start(s);
    GoodCRC_Req = 1'b0;
    c = s + int'(TMO) + 1;
    push_end(EV_TMO, c);
    while (cyc < c + 1) @(negedge CLK);
    chk("tmo_gnt_drop", 32'({PHY_Tx_Sel, HardReset_Gnt, GoodCRC_Gnt, Msg_Gnt}), 32'h0);

    // Done on the timeout cycle wins.
    wait_idle(c);
    GoodCRC_Req = 1'b1;
    push_start(2'b01, cyc + 1);
    wait_start(s);
    GoodCRC_Req = 1'b0;
    finish_tx(s, int'(TMO), 1'b0, c);

    // Done together with HR on a message: normal completion, no abort.
    wait_idle(c);
    Msg_Req = 1'b1;
    push_start(2'b10, cyc + 1);
    wait_start(s);
    Msg_Req = 1'b0;
    finish_tx(s, 5, 1'b1, c);

    // Reset in the middle of a transaction clears everything silently.
    wait_idle(c);
    GoodCRC_Req = 1'b1;
    push_start(2'b01, cyc + 1);
    wait_start(s);
    while (cyc < s + 3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("reset_mid", 32'(outs()), 32'h0);
    GoodCRC_Req = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    HardReset_Req = 1'b1;
    push_start(2'b11, cyc + 1);
    wait_start(s);
    HardReset_Req = 1'b0;
    finish_tx(s, 3, 1'b0, c);

    repeat (20) @(negedge CLK);
    chk("sb_empty", 32'(start_sb.size() + end_sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
